// File: rtl/load_store_unit_if.sv
// Bundle of the load/store unit's three handshakes: the execute-stage request,
// the word-aligned memory bus and the register-file writeback.
// The master modport is the load/store unit itself, which masters the memory
// bus and produces the writeback. The slave modport is everything around it:
// the execute stage, the memory and the register file.
interface load_store_unit_if #(
   parameter int ADDR_W = 32
);
   // execute-stage request
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [4:0]        req_rd;

   // word-aligned memory bus
   logic              mem_valid;
   logic              mem_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   // register-file writeback
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [31:0]       wb_data;
   logic [2:0]        wb_sel;

   modport master (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      output req_ready,
      output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ready, mem_rvalid, mem_rdata,
      output wb_valid, wb_rd, wb_data, wb_sel
   );

   modport slave (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      input  req_ready,
      input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ready, mem_rvalid, mem_rdata,
      input  wb_valid, wb_rd, wb_data, wb_sel
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time, drives a word-aligned
// valid/ready memory bus with byte enables, splits accesses that cross a
// word boundary into two beats, and returns raw right-justified load bytes
// plus a select code that tells the register file how to extend them.
module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   load_store_unit_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ0  = 3'd1,
      WAIT0 = 3'd2,
      REQ1  = 3'd3,
      WAIT1 = 3'd4,
      WB    = 3'd5
   } state_t;

   // Byte-lane mask across the two-word window {beat1, beat0}.
   function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [7:0] base;
      case (size)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         default: base = 8'h0F;
      endcase
      lane_mask = base << off;
   endfunction

   // Store data moved onto its byte lanes across the two-word window.
   function automatic logic [63:0] store_lanes(input logic [31:0] wdata, input logic [1:0] off);
      store_lanes = {32'h0, wdata} << {off, 3'b000};
   endfunction

   // Right-justify the addressed bytes of the two read beats; upper bits zero.
   function automatic logic [31:0] load_merge(input logic [31:0] hi, input logic [31:0] lo,
                                              input logic [1:0] size, input logic [1:0] off);
      logic [31:0] win;
      win = 32'({hi, lo} >> {off, 3'b000});
      case (size)
         2'd0:    load_merge = {24'h0, win[7:0]};
         2'd1:    load_merge = {16'h0, win[15:0]};
         default: load_merge = win;
      endcase
   endfunction

   // Writeback select: 1=LW, 2=LB, 3=LH, 4=LBU, 5=LHU (reserved size acts as word).
   function automatic logic [2:0] wb_code(input logic [1:0] size, input logic uns);
      case (size)
         2'd0:    wb_code = uns ? 3'd4 : 3'd2;
         2'd1:    wb_code = uns ? 3'd5 : 3'd3;
         default: wb_code = 3'd1;
      endcase
   endfunction

   state_t state;
   state_t state_nxt;

   // captured request
   logic              we_p0;
   logic [1:0]        size_p0;
   logic              uns_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [31:0]       wdata_p0;
   logic [4:0]        rd_p0;

   // returned read beats
   logic [31:0]       rdata0_p1;
   logic [31:0]       rdata1_p1;

   logic [1:0]        off_p0;
   logic [7:0]        mask_p0;
   logic [63:0]       lanes_p0;
   logic              split_p0;
   logic [ADDR_W-1:0] beat0_addr;
   logic [ADDR_W-1:0] beat1_addr;

   // A second beat is needed exactly when the lane mask spills past byte 3.
   assign off_p0     = addr_p0[1:0];
   assign mask_p0    = lane_mask(size_p0, off_p0);
   assign lanes_p0   = store_lanes(wdata_p0, off_p0);
   assign split_p0   = |mask_p0[7:4];
   assign beat0_addr = {addr_p0[ADDR_W-1:2], 2'b00};
   assign beat1_addr = beat0_addr + ADDR_W'(4);

   // State register; reset abandons any bus transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // --- stage p0: request capture ---
   // Hold the accepted request for the whole transaction.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.req_valid) begin
         we_p0    <= bus.req_we;
         size_p0  <= bus.req_size;
         uns_p0   <= bus.req_unsigned;
         addr_p0  <= bus.req_addr;
         wdata_p0 <= bus.req_wdata;
         rd_p0    <= bus.req_rd;
      end
   end

   // --- stage p1: read beats ---
   // Keep each returned word; lanes outside the access are dropped at merge.
   always_ff @(posedge clk) begin
      if (state == WAIT0 && bus.mem_rvalid) begin
         rdata0_p1 <= bus.mem_rdata;
      end
      if (state == WAIT1 && bus.mem_rvalid) begin
         rdata1_p1 <= bus.mem_rdata;
      end
   end

   // Next-state and outputs; every output is decoded from state so that
   // reset returns all of them to zero (req_ready to one) at once, and bus
   // fields stay stable while a beat waits for mem_ready.
   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_be    = '0;
      bus.wb_valid  = 1'b0;
      bus.wb_rd     = '0;
      bus.wb_data   = '0;
      bus.wb_sel    = '0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               state_nxt = REQ0;
            end
         end
         REQ0: begin
            bus.mem_valid = 1'b1;
            bus.mem_we    = we_p0;
            bus.mem_addr  = beat0_addr;
            bus.mem_wdata = we_p0 ? lanes_p0[31:0] : 32'h0;
            bus.mem_be    = mask_p0[3:0];
            if (bus.mem_ready) begin
               if (!we_p0) begin
                  state_nxt = WAIT0;
               end else if (split_p0) begin
                  state_nxt = REQ1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         WAIT0: begin
            if (bus.mem_rvalid) begin
               state_nxt = split_p0 ? REQ1 : WB;
            end
         end
         REQ1: begin
            bus.mem_valid = 1'b1;
            bus.mem_we    = we_p0;
            bus.mem_addr  = beat1_addr;
            bus.mem_wdata = we_p0 ? lanes_p0[63:32] : 32'h0;
            bus.mem_be    = mask_p0[7:4];
            if (bus.mem_ready) begin
               state_nxt = we_p0 ? IDLE : WAIT1;
            end
         end
         WAIT1: begin
            if (bus.mem_rvalid) begin
               state_nxt = WB;
            end
         end
         WB: begin
            bus.wb_valid = 1'b1;
            bus.wb_rd    = rd_p0;
            bus.wb_data  = load_merge(rdata1_p1, rdata0_p1, size_p0, off_p0);
            bus.wb_sel   = wb_code(size_p0, uns_p0);
            state_nxt    = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes the expected bus beats
// and writebacks into queues, a negedge monitor pops and compares them whenever
// the DUT presents a beat or a writeback, and a memory responder answers reads.
module tb_load_store_unit;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } beat_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [2:0]  sel;
   } wbexp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_W(32)) bus ();

   load_store_unit #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   beat_t       exp_beat[$];
   wbexp_t      exp_wb[$];
   logic [31:0] rdata_q[$];

   // monitor-owned
   int last_wb_cyc = -1;
   int n_wb        = 0;
   int acc_loads   = 0;

   // stimulus-owned controls read by monitor/responder
   bit resp_en  = 1'b1;
   int rv_delay = 0;
   int man_req  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] be_bits(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   task automatic exp_b(input logic [31:0] addr, input logic we, input logic [3:0] be, input logic [31:0] wdata);
      beat_t b;
      b.addr = addr; b.we = we; b.be = be; b.wdata = wdata;
      exp_beat.push_back(b);
   endtask

   task automatic exp_w(input logic [4:0] rd, input logic [31:0] data, input logic [2:0] sel);
      wbexp_t w;
      w.rd = rd; w.data = data; w.sel = sel;
      exp_wb.push_back(w);
   endtask

   // Monitor: compare every accepted bus beat and every writeback pulse.
   initial begin
      beat_t  b;
      wbexp_t w;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (bus.mem_valid && bus.mem_ready) begin
               if (exp_beat.size() == 0) begin
                  check("beat_unexpected", {32'h0, bus.mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  b = exp_beat.pop_front();
                  check("beat_addr", {32'h0, bus.mem_addr}, {32'h0, b.addr});
                  check("beat_we", {63'h0, bus.mem_we}, {63'h0, b.we});
                  check("beat_be", {60'h0, bus.mem_be}, {60'h0, b.be});
                  if (b.we) begin
                     check("beat_wdata", {32'h0, bus.mem_wdata & be_bits(b.be)}, {32'h0, b.wdata & be_bits(b.be)});
                  end
               end
               if (!bus.mem_we && resp_en) acc_loads++;
            end
            if (bus.wb_valid) begin
               last_wb_cyc = cyc;
               n_wb++;
               if (exp_wb.size() == 0) begin
                  check("wb_unexpected", {32'h0, bus.wb_data}, 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  w = exp_wb.pop_front();
                  check("wb_rd", {59'h0, bus.wb_rd}, {59'h0, w.rd});
                  check("wb_data", {32'h0, bus.wb_data}, {32'h0, w.data});
                  check("wb_sel", {61'h0, bus.wb_sel}, {61'h0, w.sel});
               end
            end
         end
      end
   end

   // Memory responder: answers each accepted read beat after rv_delay cycles,
   // or injects one stray rvalid when the stimulus asks for it.
   initial begin
      int served  = 0;
      int rv_cnt  = 0;
      int man_done = 0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_rvalid = 1'b0;
         if (man_req != man_done) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h5A5A_5A5A;
            man_done++;
         end else if (acc_loads > served) begin
            if (rv_cnt < rv_delay) begin
               rv_cnt++;
            end else begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
               served++;
               rv_cnt = 0;
            end
         end
      end
   end

   // Present a request until accepted; returns the acceptance cycle.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, output int acc);
      acc = -1;
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_rd       = rd;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            acc = cyc;
            break;
         end
      end
      check("req_accept_timeout", {63'h0, acc >= 0}, 64'h1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   // Wait, bounded, until the unit is idle and the scoreboard has drained.
   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.req_ready && exp_beat.size() == 0 && exp_wb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain_timeout", {63'h0, ok}, 64'h1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_req_ready"}, {63'h0, bus.req_ready}, 64'h1);
      check({tag, "_mem_ctl"}, {58'h0, bus.mem_valid, bus.mem_we, bus.mem_be}, 64'h0);
      check({tag, "_mem_addr"}, {32'h0, bus.mem_addr}, 64'h0);
      check({tag, "_mem_wdata"}, {32'h0, bus.mem_wdata}, 64'h0);
      check({tag, "_wb_ctl"}, {55'h0, bus.wb_valid, bus.wb_rd, bus.wb_sel}, 64'h0);
      check({tag, "_wb_data"}, {32'h0, bus.wb_data}, 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed sequence.
   initial begin
      int acc;
      int wb_before;
      rst = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      bus.req_rd       = 5'd0;
      bus.mem_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Aligned LW, latency 3
      exp_b(32'h100, 1'b0, 4'hF, 32'h0);
      exp_w(5'd5, 32'hDEAD_BEEF, 3'd1);
      rdata_q.push_back(32'hDEAD_BEEF);
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5, acc);
      wait_done();
      check("lw_latency", 64'(last_wb_cyc - acc), 64'd3);

      // LBU then LB at 0x203
      exp_b(32'h200, 1'b0, 4'b1000, 32'h0);
      exp_w(5'd6, 32'h0000_0080, 3'd4);
      rdata_q.push_back(32'h80FF_1234);
      issue(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 5'd6, acc);
      wait_done();
      exp_b(32'h200, 1'b0, 4'b1000, 32'h0);
      exp_w(5'd7, 32'h0000_0080, 3'd2);
      rdata_q.push_back(32'h80FF_1234);
      issue(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 5'd7, acc);
      wait_done();

      // Split SW at 0x1FE
      wb_before = n_wb;
      exp_b(32'h1FC, 1'b1, 4'b1100, 32'hCCDD_0000);
      exp_b(32'h200, 1'b1, 4'b0011, 32'h0000_AABB);
      issue(1'b1, 2'd2, 1'b0, 32'h1FE, 32'hAABB_CCDD, 5'd1, acc);
      wait_done();
      check("split_sw_no_wb", 64'(n_wb - wb_before), 64'd0);

      // Split LH at 0x7
      exp_b(32'h4, 1'b0, 4'b1000, 32'h0);
      exp_b(32'h8, 1'b0, 4'b0001, 32'h0);
      exp_w(5'd9, 32'h0000_2211, 3'd3);
      rdata_q.push_back(32'h1122_3344);
      rdata_q.push_back(32'h5566_7722);
      issue(1'b0, 2'd1, 1'b0, 32'h7, 32'h0, 5'd9, acc);
      wait_done();

      // Aligned SW, req_ready back at cycle 2
      wb_before = n_wb;
      exp_b(32'h300, 1'b1, 4'hF, 32'h1234_5678);
      issue(1'b1, 2'd2, 1'b0, 32'h300, 32'h1234_5678, 5'd2, acc);
      @(negedge clk);
      check("sw_ready_c1", {63'h0, bus.req_ready}, 64'h0);
      @(negedge clk);
      check("sw_ready_c2", {63'h0, bus.req_ready}, 64'h1);
      wait_done();
      check("sw_no_wb", 64'(n_wb - wb_before), 64'd0);

      // SB at 0x105 with garbage in upper store bits
      exp_b(32'h104, 1'b1, 4'b0010, 32'h0000_A500);
      issue(1'b1, 2'd0, 1'b0, 32'h105, 32'hFFFF_FFA5, 5'd0, acc);
      wait_done();

      // LHU at 0x102 with slow read return
      rv_delay = 2;
      exp_b(32'h100, 1'b0, 4'b1100, 32'h0);
      exp_w(5'd10, 32'h0000_8001, 3'd5);
      rdata_q.push_back(32'h8001_5555);
      issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 5'd10, acc);
      wait_done();
      rv_delay = 0;

      // Split LW at off=1
      exp_b(32'hC, 1'b0, 4'b1110, 32'h0);
      exp_b(32'h10, 1'b0, 4'b0001, 32'h0);
      exp_w(5'd11, 32'h44AA_BBCC, 3'd1);
      rdata_q.push_back(32'hAABB_CCDD);
      rdata_q.push_back(32'h1122_3344);
      issue(1'b0, 2'd2, 1'b0, 32'hD, 32'h0, 5'd11, acc);
      wait_done();

      // Split LW wrapping past the top of the address space
      exp_b(32'hFFFF_FFFC, 1'b0, 4'b1100, 32'h0);
      exp_b(32'h0, 1'b0, 4'b0011, 32'h0);
      exp_w(5'd13, 32'h7788_5566, 3'd1);
      rdata_q.push_back(32'h5566_0000);
      rdata_q.push_back(32'h0000_7788);
      issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 5'd13, acc);
      wait_done();

      // Split SH at off=3
      exp_b(32'hFC, 1'b1, 4'b1000, 32'hEF00_0000);
      exp_b(32'h100, 1'b1, 4'b0001, 32'h0000_00BE);
      issue(1'b1, 2'd1, 1'b0, 32'hFF, 32'h1234_BEEF, 5'd0, acc);
      wait_done();

      // Reserved size behaves as word
      exp_b(32'h500, 1'b0, 4'hF, 32'h0);
      exp_w(5'd12, 32'h7654_3210, 3'd1);
      rdata_q.push_back(32'h7654_3210);
      issue(1'b0, 2'd3, 1'b1, 32'h500, 32'h0, 5'd12, acc);
      wait_done();

      // Backpressure: mem_ready low for 3 cycles in REQ0, competing request held
      bus.mem_ready = 1'b0;
      exp_b(32'h400, 1'b1, 4'hF, 32'hCAFE_F00D);
      issue(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFE_F00D, 5'd0, acc);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'h800;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_mem_valid", {63'h0, bus.mem_valid}, 64'h1);
         check("bp_addr", {32'h0, bus.mem_addr}, 64'h400);
         check("bp_be_we", {59'h0, bus.mem_we, bus.mem_be}, {59'h0, 1'b1, 4'hF});
         check("bp_wdata", {32'h0, bus.mem_wdata}, 64'hCAFE_F00D);
         check("bp_req_ready", {63'h0, bus.req_ready}, 64'h0);
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
      bus.mem_ready = 1'b1;
      wait_done();

      // Reset while in WAIT0; a late rvalid must not produce a writeback
      resp_en = 1'b0;
      exp_b(32'h40, 1'b0, 4'hF, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd3, acc);
      @(posedge clk);
      #1;
      wb_before = n_wb;
      rst = 1'b0;
      #1;
      check_idle("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      resp_en = 1'b1;
      man_req++;
      repeat (5) @(posedge clk);
      #1;
      check("reset_no_wb", 64'(n_wb - wb_before), 64'd0);

      // Recovery after reset
      exp_b(32'h600, 1'b0, 4'hF, 32'h0);
      exp_w(5'd31, 32'h0BAD_F00D, 3'd1);
      rdata_q.push_back(32'h0BAD_F00D);
      issue(1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 5'd31, acc);
      wait_done();

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side data-memory access engine: the other end of the register-file write port, producing the load data and load-type code that the register file extends and writes.
- Accepts one load/store request at a time from the execute stage and drives a word-aligned valid/ready memory bus with byte enables.
- Splits misaligned accesses into two word beats and merges load bytes.
- Returns right-justified raw load data with a writeback select code; sign/zero extension is done by the register file.

Parameters:
ADDR_W, 32, width of request and memory addresses (bits [1:0] are the byte offset)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
req_unsigned  input  1  load is unsigned (LBU/LHU); ignored for word and for stores
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified
req_rd  input  5  load destination register
mem_valid  output  1  bus request valid
mem_ready  input  1  bus accepts the request this cycle
mem_we  output  1  bus write
mem_addr  output  ADDR_W  word-aligned address, bits [1:0] always 0
mem_wdata  output  32  lane-positioned write data
mem_be  output  4  byte enables
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data
wb_valid  output  1  load result valid, one-cycle pulse
wb_rd  output  5  destination register
wb_data  output  32  raw load bytes, right-justified, upper bits zero
wb_sel  output  3  1=LW, 2=LB, 3=LH, 4=LBU, 5=LHU; 0 when wb_valid=0

Behaviour:
- Reset (async, rst=0): state IDLE. All outputs 0 except req_ready=1. Any in-flight bus transaction is abandoned; a late mem_rvalid after reset is ignored.
- Handshake: a request is captured when req_valid & req_ready.
  - Captured fields: we, size, unsigned, addr, wdata, rd.
  - Derived: off = addr[1:0]; nbytes = 1, 2 or 4; split = (off + nbytes > 4).
- States:
  - IDLE: req_ready=1. On accept -> REQ0.
  - REQ0: mem_valid=1, mem_addr = {addr[ADDR_W-1:2],2'b00}. On mem_ready: store and !split -> IDLE; load -> WAIT0; store and split -> REQ1.
  - WAIT0: on mem_rvalid, latch the lanes used in beat 0. Then split -> REQ1, else -> WB.
  - REQ1: mem_valid=1, mem_addr = beat-0 address + 4 (wraps modulo 2^ADDR_W). On mem_ready: store -> IDLE; load -> WAIT1.
  - WAIT1: on mem_rvalid, latch beat-1 lanes -> WB.
  - WB: wb_valid=1 for exactly one cycle -> IDLE.
- Bus rules:
  - While mem_valid=1 and mem_ready=0, mem_addr, mem_we, mem_wdata and mem_be hold stable.
  - mem_valid drops in the cycle after acceptance.
- Lane mapping: form a 64-bit window {beat1, beat0}.
  - Store: data = req_wdata << (8*off); mask = ((1<<nbytes)-1) << off.
  - Beat 0 uses data[31:0] and mask[3:0]; beat 1 uses data[63:32] and mask[7:4].
  - mem_be = the mask bits for the current beat.
  - Loads drive mem_be equal to the same mask and mem_we=0.
- Load merge: wb_data = ({beat1_rdata, beat0_rdata} >> (8*off)), masked to nbytes; upper bits zero.
- wb_sel encoding:
  - word -> 1
  - byte -> 2 if signed, 4 if unsigned
  - half -> 3 if signed, 5 if unsigned
- Split cases: half at off=3; word at off=1, 2, 3. Bytes never split.
- mem_rvalid outside WAIT0/WAIT1 is ignored. mem_ready is ignored when mem_valid=0.
- Latency, aligned load with mem_ready=1 and rvalid one cycle after acceptance: request accepted at cycle 0 -> wb_valid at cycle 3.
- Latency, aligned store with mem_ready=1: request accepted at cycle 0 -> req_ready high again at cycle 2.
- stores never assert wb_valid.

Test Plan:
- Aligned LW addr=0x100, rdata=0xDEADBEEF, ready=1, rvalid next cycle -> mem_addr=0x100, be=4'hF; wb_valid at cycle 3, wb_data=0xDEADBEEF, wb_sel=1, wb_rd matches req_rd.
- LBU addr=0x203 and LB addr=0x203 with rdata=0x80FF_1234 -> be=4'b1000, wb_data=0x00000080, wb_sel=4 then 2.
- Split SW addr=0x1FE, wdata=0xAABBCCDD -> beat0 addr=0x1FC, be=4'b1100, wdata=0xCCDD_xxxx; beat1 addr=0x200, be=4'b0011, wdata lanes[15:0]=0xAABB; no wb_valid.
- Split LH addr=0x7, beat0 rdata=0x11xxxxxx, beat1 rdata=0xxxxxxx22 -> addr 0x4 then 0x8, wb_data=0x00002211, wb_sel=3.
- Bus backpressure: mem_ready low for 3 cycles in REQ0 -> mem_valid, addr, be, wdata stable throughout; req_ready stays 0; new req_valid is not accepted.
- rst pulsed low while in WAIT0, with mem_rvalid arriving afterwards -> all outputs 0 and req_ready=1 immediately; no wb_valid is produced.
